// File: rtl/ah_cam_pkg.sv
// Shared definitions for the CAM write issuer: FSM state enum, counter-width
// helper and default geometry constants.
package ah_cam_pkg;

  localparam int AH_CAM_DATAW = 10;
  localparam int AH_CAM_DEPTH = 10;

  typedef enum logic [1:0] {
    INIT    = 2'd0,
    RUN     = 2'd1,
    STARVED = 2'd2
  } ah_camwr_state_e;

  // Bits needed to hold a credit count from 0 up to and including depth.
  function automatic int ah_cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/ah_fifo2.sv
// Two-entry synchronous FIFO used as the issuer's input buffer.
// The caller must not push while full or pop while empty.
module ah_fifo2 #(
  parameter int DATAW = 10
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push,
  input  logic             pop,
  input  logic [DATAW-1:0] push_data,
  output logic             full,
  output logic             empty,
  output logic [DATAW-1:0] head
);

  logic [DATAW-1:0] mem_q [2];
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [1:0]       cnt_q, cnt_d;

  // Next pointer and occupancy values from this cycle's push/pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q ^ push;
    rd_ptr_d = rd_ptr_q ^ pop;
    cnt_d    = cnt_q;
    if (push && !pop) begin
      cnt_d = cnt_q + 2'd1;
    end else if (!push && pop) begin
      cnt_d = cnt_q - 2'd1;
    end
  end

  // Control state; reset discards any buffered entries.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  assign full  = (cnt_q == 2'd2);
  assign empty = (cnt_q == 2'd0);
  assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/ah_cam_wr_issuer.sv
// Credit-based write issuer feeding the CAM write port. Buffers up to two
// entries and issues one registered write per cycle while credits remain.
// Optional macro AH_CAMWR_CREDIT_CHECK_EN adds a sticky credit_err output
// flagging credit returns that would exceed CAMDEPTH.
module ah_cam_wr_issuer
  import ah_cam_pkg::*;
#(
  parameter int DATAW    = AH_CAM_DATAW,
  parameter int CAMDEPTH = AH_CAM_DEPTH
) (
  input  logic                             clk,
  input  logic                             rstn,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [DATAW-1:0]                 in_data,
  output logic                             wr_valid,
  output logic [DATAW-1:0]                 wr_data,
  input  logic                             wr_credit,
  output logic [ah_cnt_w(CAMDEPTH)-1:0]    credit_cnt,
  output logic                             idle
`ifdef AH_CAMWR_CREDIT_CHECK_EN
  ,
  output logic                             credit_err
`endif
);

  localparam int              CNTW    = ah_cnt_w(CAMDEPTH);
  localparam logic [CNTW-1:0] DEPTH_C = CNTW'(CAMDEPTH);
  localparam logic [CNTW-1:0] ONE_C   = CNTW'(1);

  ah_camwr_state_e  state_q, state_d;
  logic [CNTW-1:0]  credit_cnt_q, credit_cnt_d;
  logic             wr_valid_q, wr_valid_d;
  logic [DATAW-1:0] wr_data_q, wr_data_d;

  logic             fifo_full;
  logic             fifo_empty;
  logic [DATAW-1:0] fifo_head;
  logic             push;
  logic             pop;

  ah_fifo2 #(
    .DATAW (DATAW)
  ) u_buf (
    .clk       (clk),
    .rstn      (rstn),
    .push      (push),
    .pop       (pop),
    .push_data (in_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (fifo_head)
  );

  // in_ready depends only on registered state, never on inputs.
  assign in_ready = !fifo_full && (state_q != INIT);
  assign push     = in_valid && in_ready;
  // Issue uses the registered count, so a credit returned this cycle
  // only becomes usable on the next one.
  assign pop      = !fifo_empty && (credit_cnt_q != '0) && (state_q != INIT);

  // Credit bookkeeping: INIT loads the full pool and ignores returns;
  // afterwards an issue and a return in the same cycle cancel, and a
  // return at the full pool saturates.
  always_comb begin
    credit_cnt_d = credit_cnt_q;
    if (state_q == INIT) begin
      credit_cnt_d = DEPTH_C;
    end else if (pop && !wr_credit) begin
      credit_cnt_d = credit_cnt_q - ONE_C;
    end else if (!pop && wr_credit && (credit_cnt_q != DEPTH_C)) begin
      credit_cnt_d = credit_cnt_q + ONE_C;
    end
  end

  // FSM next state plus the registered write strobe and data.
  always_comb begin
    state_d    = state_q;
    wr_valid_d = pop;
    wr_data_d  = pop ? fifo_head : wr_data_q;
    case (state_q)
      INIT:    state_d = RUN;
      RUN:     if (credit_cnt_d == '0) state_d = STARVED;
      STARVED: if (credit_cnt_d != '0) state_d = RUN;
      default: state_d = INIT;
    endcase
  end

  // Single register block for FSM state, credit counter and write outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= INIT;
      credit_cnt_q <= '0;
      wr_valid_q   <= 1'b0;
      wr_data_q    <= '0;
    end else begin
      state_q      <= state_d;
      credit_cnt_q <= credit_cnt_d;
      wr_valid_q   <= wr_valid_d;
      wr_data_q    <= wr_data_d;
    end
  end

  assign wr_valid   = wr_valid_q;
  assign wr_data    = wr_data_q;
  assign credit_cnt = credit_cnt_q;
  assign idle       = fifo_empty && (credit_cnt_q == DEPTH_C);

`ifdef AH_CAMWR_CREDIT_CHECK_EN
  logic credit_err_q, credit_err_d;
  logic overflow;

  // A return while the pool is already full and nothing issues is an error.
  assign overflow = wr_credit && !pop && (credit_cnt_q == DEPTH_C) && (state_q != INIT);

  // Sticky error; only reset clears it.
  always_comb begin
    credit_err_d = credit_err_q | overflow;
  end

  // Error flag register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      credit_err_q <= 1'b0;
    end else begin
      credit_err_q <= credit_err_d;
    end
  end

  assign credit_err = credit_err_q;
`endif

endmodule

// File: tb/tb_ah_cam_wr_issuer.sv
// Self-checking bench for ah_cam_wr_issuer: a queue-based reference model
// checked every cycle, plus directed scenarios with literal expectations.
module tb_ah_cam_wr_issuer;

  localparam int DATAW = 10;
  localparam int DEPTH = 10;
  localparam int CNTW  = $clog2(DEPTH + 1);

  logic             clk       = 1'b0;
  logic             rstn      = 1'b0;
  logic             in_valid  = 1'b0;
  logic [DATAW-1:0] in_data   = '0;
  logic             wr_credit = 1'b0;
  logic             in_ready;
  logic             wr_valid;
  logic [DATAW-1:0] wr_data;
  logic [CNTW-1:0]  credit_cnt;
  logic             idle;
`ifdef AH_CAMWR_CREDIT_CHECK_EN
  logic             credit_err;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int wlog[$];

  always #5 clk = ~clk;

  ah_cam_wr_issuer #(
    .DATAW    (DATAW),
    .CAMDEPTH (DEPTH)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .wr_valid   (wr_valid),
    .wr_data    (wr_data),
    .wr_credit  (wr_credit),
    .credit_cnt (credit_cnt),
    .idle       (idle)
`ifdef AH_CAMWR_CREDIT_CHECK_EN
    ,
    .credit_err (credit_err)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int m_q[$];
  int m_cred = 0;
  bit m_init = 1'b1;
  bit m_wv   = 1'b0;
  int m_wd   = 0;
  bit m_err  = 1'b0;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_q.delete();
      m_cred = 0;
      m_init = 1'b1;
      m_wv   = 1'b0;
      m_wd   = 0;
      m_err  = 1'b0;
    end else if (m_init) begin
      m_cred = DEPTH;
      m_init = 1'b0;
      m_wv   = 1'b0;
    end else begin : m_step
      bit iss;
      bit acc;
      iss = (m_q.size() > 0) && (m_cred > 0);
      acc = (in_valid === 1'b1) && (m_q.size() < 2);
      m_wv = iss;
      if (iss) m_wd = m_q.pop_front();
      if (acc) m_q.push_back(int'(in_data));
      if (iss && !wr_credit) m_cred = m_cred - 1;
      else if (!iss && wr_credit) begin
        if (m_cred == DEPTH) m_err = 1'b1;
        else m_cred = m_cred + 1;
      end
    end
  end

  // Per-cycle comparison against the model, sampled after the edge settles.
  always @(posedge clk) begin
    #2;
    check("in_ready", 32'(in_ready), 32'(!m_init && (m_q.size() < 2)));
    check("wr_valid", 32'(wr_valid), 32'(m_wv));
    if (m_wv) check("wr_data", 32'(wr_data), 32'(m_wd));
    check("credit_cnt", 32'(credit_cnt), 32'(m_cred));
    check("idle", 32'(idle), 32'((m_q.size() == 0) && (m_cred == DEPTH)));
`ifdef AH_CAMWR_CREDIT_CHECK_EN
    check("credit_err", 32'(credit_err), 32'(m_err));
`endif
    if (wr_valid === 1'b1) wlog.push_back(int'(wr_data));
  end

  // Offer one entry, holding it until accepted (bounded wait).
  task automatic send(input int v);
    int waitc;
    waitc    = 0;
    in_valid = 1'b1;
    in_data  = DATAW'(v);
    while (in_ready !== 1'b1 && waitc < 50) begin
      @(negedge clk);
      waitc++;
    end
    if (waitc >= 50) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: entry 0x%0h not accepted, required acceptance within 50 cycles", v);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    for (int k = 0; k < n; k++) @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, required completion before 100000");
    $fatal(1);
  end

  initial begin
    // Reset state and single-cycle INIT
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_wr_valid", 32'(wr_valid), 32'd0);
    check("rst_wr_data", 32'(wr_data), 32'd0);
    check("rst_credit", 32'(credit_cnt), 32'd0);
    check("rst_idle", 32'(idle), 32'd0);
`ifdef AH_CAMWR_CREDIT_CHECK_EN
    check("rst_err", 32'(credit_err), 32'd0);
`endif
    rstn = 1'b1;
    @(negedge clk);
    check("init_credit", 32'(credit_cnt), 32'd10);
    check("init_in_ready", 32'(in_ready), 32'd1);
    check("init_idle", 32'(idle), 32'd1);

    // Credit exhaustion: 12 entries, no returns
    for (int i = 1; i <= 12; i++) send(i);
    idle_cycles(2);
    check("exh_credit", 32'(credit_cnt), 32'd0);
    check("exh_in_ready", 32'(in_ready), 32'd0);
    check("exh_nwrites", 32'(wlog.size()), 32'd10);
    for (int i = 0; i < wlog.size(); i++) check("exh_order", 32'(wlog[i]), 32'(i + 1));
    wlog.delete();

    // Release from starvation with one credit
    wr_credit = 1'b1;
    @(negedge clk);
    wr_credit = 1'b0;
    check("rel_credit1", 32'(credit_cnt), 32'd1);
    check("rel_no_wr", 32'(wr_valid), 32'd0);
    @(negedge clk);
    check("rel_wr_valid", 32'(wr_valid), 32'd1);
    check("rel_wr_data", 32'(wr_data), 32'h00B);
    check("rel_credit0", 32'(credit_cnt), 32'd0);

    // Drain 0x00C and build the pool up to 5
    wr_credit = 1'b1;
    idle_cycles(6);
    wr_credit = 1'b0;
    check("pre_sim_credit", 32'(credit_cnt), 32'd5);
    check("pre_sim_last", 32'(wlog[wlog.size() - 1]), 32'h00C);
    wlog.delete();

    // Simultaneous issue and return for 20 cycles
    for (int i = 0; i <= 20; i++) begin
      in_valid  = (i < 20);
      in_data   = DATAW'(32'h40 + i);
      wr_credit = (i >= 1);
      @(negedge clk);
    end
    in_valid  = 1'b0;
    wr_credit = 1'b0;
    check("sim_credit", 32'(credit_cnt), 32'd5);
    check("sim_nwrites", 32'(wlog.size()), 32'd20);
    for (int i = 0; i < wlog.size(); i++) check("sim_order", 32'(wlog[i]), 32'(32'h40 + i));
    wlog.delete();

    // Refill to a full pool, then overflow
    wr_credit = 1'b1;
    idle_cycles(5);
    wr_credit = 1'b0;
    check("ovf_pre_idle", 32'(idle), 32'd1);
    check("ovf_pre_credit", 32'(credit_cnt), 32'd10);
    wr_credit = 1'b1;
    idle_cycles(2);
    wr_credit = 1'b0;
    @(negedge clk);
    check("ovf_credit", 32'(credit_cnt), 32'd10);
    check("ovf_idle", 32'(idle), 32'd1);
`ifdef AH_CAMWR_CREDIT_CHECK_EN
    check("ovf_err", 32'(credit_err), 32'd1);
    idle_cycles(2);
    check("ovf_err_sticky", 32'(credit_err), 32'd1);
`endif

    // Latency: entry accepted at edge N is written after edge N+1
    in_valid = 1'b1;
    in_data  = 10'h155;
    @(negedge clk);
    in_valid = 1'b0;
    check("lat_n", 32'(wr_valid), 32'd0);
    @(negedge clk);
    check("lat_n1_valid", 32'(wr_valid), 32'd1);
    check("lat_n1_data", 32'(wr_data), 32'h155);
    check("lat_credit", 32'(credit_cnt), 32'd9);
    wlog.delete();

    // Reset mid-operation with two entries buffered
    for (int i = 0; i <= 10; i++) send(32'h60 + i);
    @(negedge clk);
    check("mid_credit", 32'(credit_cnt), 32'd0);
    check("mid_full", 32'(in_ready), 32'd0);
    check("mid_nwrites", 32'(wlog.size()), 32'd9);
    rstn      = 1'b0;
    wr_credit = 1'b1;
    #1;
    check("mid_rst_in_ready", 32'(in_ready), 32'd0);
    check("mid_rst_wr_valid", 32'(wr_valid), 32'd0);
    check("mid_rst_wr_data", 32'(wr_data), 32'd0);
    check("mid_rst_credit", 32'(credit_cnt), 32'd0);
    check("mid_rst_idle", 32'(idle), 32'd0);
`ifdef AH_CAMWR_CREDIT_CHECK_EN
    check("mid_rst_err", 32'(credit_err), 32'd0);
`endif
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    wr_credit = 1'b0;
    check("mid_init_credit", 32'(credit_cnt), 32'd10);
    check("mid_init_idle", 32'(idle), 32'd1);
    idle_cycles(5);
    begin
      int leaked;
      leaked = 0;
      foreach (wlog[i]) if (wlog[i] == 32'h69 || wlog[i] == 32'h6A) leaked++;
      check("mid_discarded", 32'(leaked), 32'd0);
    end
    check("mid_end_credit", 32'(credit_cnt), 32'd10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
